// File: rtl/fetch_realign_buffer.sv
// Instruction realigner and fetch queue: splits halfword-aligned fetch blocks into RVC/RVI
// instructions, stitching 32-bit instructions that straddle blocks, and queues them for decode.
module fetch_realign_buffer #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  input  logic [8*FETCH_BYTES-1:0]     fetch_data_i,
  input  logic [63:0]                  fetch_vaddr_i,
  input  logic                         fetch_ex_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [31:0]                  instr_o,
  output logic [63:0]                  instr_addr_o,
  output logic                         instr_rvc_o,
  output logic                         instr_ex_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned H     = FETCH_BYTES / 2;
  localparam int unsigned OffW  = $clog2(FETCH_BYTES);
  localparam int unsigned SlotW = OffW - 1;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        rvc;
    logic        ex;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_instr_q, pend_instr_d;
  logic [63:0]     pend_addr_q, pend_addr_d;

  entry_t          push_entry [H];
  logic [CntW-1:0] n_push;
  logic            scan_pend;
  logic [15:0]     scan_pend_instr;
  logic [63:0]     scan_pend_addr;
  logic [15:0]     slots [H+1];
  logic [SlotW-1:0] start_slot;
  logic [63:0]     base_addr;
  logic            cont;
  logic            accept;
  logic            pop;
  entry_t          head;

  logic unused_vaddr_lsb;
  assign unused_vaddr_lsb = fetch_vaddr_i[0];

  assign start_slot = fetch_vaddr_i[OffW-1:1];
  assign base_addr  = {fetch_vaddr_i[63:OffW], {OffW{1'b0}}};
  assign cont       = pend_q && (start_slot == '0) && (base_addr == pend_addr_q + 64'd2);

  // Admission reserves room for a worst-case block of H entries using the registered count.
  assign fetch_ready_o = (CntW'(DEPTH) - count_q) >= CntW'(H);
  assign instr_valid_o = (count_q != '0);
  assign accept        = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop           = instr_valid_o & instr_ready_i & ~flush_i;

  always_comb begin
    int   np;
    logic skip;
    np              = 0;
    skip            = 1'b0;
    scan_pend       = 1'b0;
    scan_pend_instr = pend_instr_q;
    scan_pend_addr  = pend_addr_q;
    for (int i = 0; i < int'(H); i++) begin
      push_entry[i] = '0;
      slots[i]      = fetch_data_i[16*i +: 16];
    end
    slots[H] = '0;

    if (fetch_ex_i) begin
      push_entry[0].addr = cont ? pend_addr_q : fetch_vaddr_i;
      push_entry[0].ex   = 1'b1;
      np                 = 1;
    end else begin
      for (int k = 0; k < int'(H); k++) begin
        if (skip) begin
          skip = 1'b0;
        end else if (k >= int'(start_slot)) begin
          if (cont && (k == int'(start_slot))) begin
            push_entry[np].instr = {slots[k], pend_instr_q};
            push_entry[np].addr  = pend_addr_q;
            np                   = np + 1;
          end else if (slots[k][1:0] != 2'b11) begin
            push_entry[np].instr = {16'h0000, slots[k]};
            push_entry[np].addr  = base_addr + 64'(2 * k);
            push_entry[np].rvc   = 1'b1;
            np                   = np + 1;
          end else if (k < int'(H) - 1) begin
            push_entry[np].instr = {slots[k+1], slots[k]};
            push_entry[np].addr  = base_addr + 64'(2 * k);
            np                   = np + 1;
            skip                 = 1'b1;
          end else begin
            // Upper half arrives with the next block.
            scan_pend       = 1'b1;
            scan_pend_instr = slots[k];
            scan_pend_addr  = base_addr + 64'(2 * k);
          end
        end
      end
    end
    n_push = CntW'(np);
  end

  always_comb begin
    pend_d       = pend_q;
    pend_instr_d = pend_instr_q;
    pend_addr_d  = pend_addr_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (flush_i) begin
      pend_d   = 1'b0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) begin
        pend_d       = scan_pend;
        pend_instr_d = scan_pend_instr;
        pend_addr_d  = scan_pend_addr;
        wr_ptr_d     = wr_ptr_q + n_push[PtrW-1:0];
      end
      count_d  = count_q + (accept ? n_push : '0) - CntW'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q       <= 1'b0;
      pend_instr_q <= '0;
      pend_addr_q  <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_instr_q <= pend_instr_d;
      pend_addr_q  <= pend_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int i = 0; i < int'(H); i++) begin
        if (CntW'(i) < n_push) begin
          mem_q[wr_ptr_q + PtrW'(i)] <= push_entry[i];
        end
      end
    end
  end

  // Storage is not reset, so the head is masked while the queue is empty.
  assign head         = mem_q[rd_ptr_q];
  assign instr_o      = instr_valid_o ? head.instr : '0;
  assign instr_addr_o = instr_valid_o ? head.addr  : '0;
  assign instr_rvc_o  = instr_valid_o & head.rvc;
  assign instr_ex_o   = instr_valid_o & head.ex;
  assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_realign_buffer.sv
// Directed bench for fetch_realign_buffer: a 4-byte and an 8-byte instance, hand-computed vectors.
module tb_fetch_realign_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, instr_ready, ex;
  logic [63:0] vaddr;

  logic        f4_valid, f4_ready, v4, rvc4, ex4;
  logic [31:0] f4_data, instr4;
  logic [63:0] addr4;
  logic [3:0]  count4;

  logic        f8_valid, f8_ready, v8, rvc8, ex8;
  logic [63:0] f8_data, addr8;
  logic [31:0] instr8;
  logic [3:0]  count8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_realign_buffer #(.FETCH_BYTES(4), .DEPTH(8)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_valid_i(f4_valid), .fetch_ready_o(f4_ready), .fetch_data_i(f4_data),
    .fetch_vaddr_i(vaddr), .fetch_ex_i(ex),
    .instr_valid_o(v4), .instr_ready_i(instr_ready), .instr_o(instr4),
    .instr_addr_o(addr4), .instr_rvc_o(rvc4), .instr_ex_o(ex4), .count_o(count4)
  );

  fetch_realign_buffer #(.FETCH_BYTES(8), .DEPTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_valid_i(f8_valid), .fetch_ready_o(f8_ready), .fetch_data_i(f8_data),
    .fetch_vaddr_i(vaddr), .fetch_ex_i(ex),
    .instr_valid_o(v8), .instr_ready_i(instr_ready), .instr_o(instr8),
    .instr_addr_o(addr8), .instr_rvc_o(rvc8), .instr_ex_o(ex8), .count_o(count8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [63:0] va, input logic [31:0] d, input logic e);
    f4_valid = 1'b1; vaddr = va; f4_data = d; ex = e;
    step();
    f4_valid = 1'b0; ex = 1'b0;
  endtask

  task automatic push8(input logic [63:0] va, input logic [63:0] d);
    f8_valid = 1'b1; vaddr = va; f8_data = d; ex = 1'b0;
    step();
    f8_valid = 1'b0;
  endtask

  task automatic pop();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic head4(input string tag, input logic [31:0] i, input logic [63:0] a,
                       input logic r, input logic e);
    check_eq({tag, ".valid"}, 64'(v4), 64'd1);
    check_eq({tag, ".instr"}, 64'(instr4), 64'(i));
    check_eq({tag, ".addr"}, addr4, a);
    check_eq({tag, ".rvc"}, 64'(rvc4), 64'(r));
    check_eq({tag, ".ex"}, 64'(ex4), 64'(e));
    pop();
  endtask

  task automatic head8(input string tag, input logic [31:0] i, input logic [63:0] a,
                       input logic r);
    check_eq({tag, ".instr"}, 64'(instr8), 64'(i));
    check_eq({tag, ".addr"}, addr8, a);
    check_eq({tag, ".rvc"}, 64'(rvc8), 64'(r));
    pop();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; ex = 1'b0; vaddr = '0;
    f4_valid = 1'b0; f4_data = '0; f8_valid = 1'b0; f8_data = '0;
    step(); step();
    check_eq("rst.count4", 64'(count4), 64'd0);
    check_eq("rst.valid4", 64'(v4), 64'd0);
    check_eq("rst.ready4", 64'(f4_ready), 64'd1);
    check_eq("rst.instr4", 64'(instr4), 64'd0);
    check_eq("rst.addr4", addr4, 64'd0);
    check_eq("rst.ready8", 64'(f8_ready), 64'd1);
    check_eq("rst.count8", 64'(count8), 64'd0);
    rst = 1'b0;
    step();

    // Two RVC in one 4-byte block.
    push4(64'h1000, 32'h0001_4501, 1'b0);
    check_eq("two_rvc.count", 64'(count4), 64'd2);
    head4("two_rvc.h0", 32'h0000_4501, 64'h1000, 1'b1, 1'b0);
    head4("two_rvc.h1", 32'h0000_0001, 64'h1002, 1'b1, 1'b0);
    check_eq("two_rvc.empty", 64'(count4), 64'd0);

    // 32-bit instruction straddling two blocks.
    push4(64'h1000, 32'h0513_0001, 1'b0);
    check_eq("straddle.count1", 64'(count4), 64'd1);
    push4(64'h1004, 32'h0000_00A0, 1'b0);
    check_eq("straddle.count2", 64'(count4), 64'd3);
    head4("straddle.h0", 32'h0000_0001, 64'h1000, 1'b1, 1'b0);
    head4("straddle.h1", 32'h00A0_0513, 64'h1002, 1'b0, 1'b0);
    head4("straddle.h2", 32'h0000_0000, 64'h1006, 1'b1, 1'b0);

    // Held halfword dropped on discontinuity.
    push4(64'h1000, 32'h0513_0001, 1'b0);
    push4(64'h2000, 32'h4501_4502, 1'b0);
    check_eq("discont.count", 64'(count4), 64'd3);
    head4("discont.h0", 32'h0000_0001, 64'h1000, 1'b1, 1'b0);
    head4("discont.h1", 32'h0000_4502, 64'h2000, 1'b1, 1'b0);
    head4("discont.h2", 32'h0000_4501, 64'h2002, 1'b1, 1'b0);

    // Exception entry takes the held address, then flush with pop and offered block.
    push4(64'h1000, 32'h0513_0001, 1'b0);
    push4(64'h1004, 32'hFFFF_FFFF, 1'b1);
    check_eq("exc.count", 64'(count4), 64'd2);
    head4("exc.h0", 32'h0000_0001, 64'h1000, 1'b1, 1'b0);
    check_eq("exc.ex", 64'(ex4), 64'd1);
    check_eq("exc.addr", addr4, 64'h1002);
    check_eq("exc.instr", 64'(instr4), 64'd0);
    check_eq("exc.rvc", 64'(rvc4), 64'd0);
    flush = 1'b1; instr_ready = 1'b1; f4_valid = 1'b1; vaddr = 64'h3000; f4_data = 32'h0001_0001;
    step();
    flush = 1'b0; instr_ready = 1'b0; f4_valid = 1'b0;
    check_eq("flush.count", 64'(count4), 64'd0);
    check_eq("flush.valid", 64'(v4), 64'd0);

    // Flush drops a held halfword; exception without held data uses fetch_vaddr_i.
    push4(64'h1000, 32'h0513_0001, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    push4(64'h1004, 32'h0000_00A0, 1'b0);
    check_eq("flushpend.count", 64'(count4), 64'd2);
    head4("flushpend.h0", 32'h0000_00A0, 64'h1004, 1'b1, 1'b0);
    pop();
    push4(64'h3002, 32'h0513_0513, 1'b1);
    check_eq("exc_nopend.count", 64'(count4), 64'd1);
    head4("exc_nopend.h0", 32'h0000_0000, 64'h3002, 1'b0, 1'b1);

    // 8-byte block: start slot 3 ignores lower slots.
    push8(64'h1006, 64'h4501_FFFF_FFFF_FFFF);
    check_eq("offset.count", 64'(count8), 64'd1);
    head8("offset.h0", 32'h0000_4501, 64'h1006, 1'b1);
    check_eq("offset.empty", 64'(count8), 64'd0);

    // 8-byte block with an inner 32-bit instruction.
    push8(64'h2000, 64'h4501_00A0_0513_0001);
    check_eq("inner32.count", 64'(count8), 64'd3);
    head8("inner32.h0", 32'h0000_0001, 64'h2000, 1'b1);
    head8("inner32.h1", 32'h00A0_0513, 64'h2002, 1'b0);
    head8("inner32.h2", 32'h0000_4501, 64'h2006, 1'b1);

    // Backpressure with worst-case admission.
    push8(64'h4000, 64'h0001_0001_0001_0001);
    check_eq("bp.count4", 64'(count8), 64'd4);
    check_eq("bp.ready4", 64'(f8_ready), 64'd1);
    push8(64'h4008, 64'h0001_0001_0001_0001);
    check_eq("bp.count8", 64'(count8), 64'd8);
    check_eq("bp.ready8", 64'(f8_ready), 64'd0);
    f8_valid = 1'b1; vaddr = 64'h4010;
    step();
    check_eq("bp.blocked", 64'(count8), 64'd8);
    instr_ready = 1'b1;
    step();
    check_eq("bp.count7", 64'(count8), 64'd7);
    check_eq("bp.ready7", 64'(f8_ready), 64'd0);
    step(); step();
    check_eq("bp.ready5", 64'(f8_ready), 64'd0);
    step();
    check_eq("bp.count_at4", 64'(count8), 64'd4);
    check_eq("bp.ready_at4", 64'(f8_ready), 64'd1);
    step();
    f8_valid = 1'b0; instr_ready = 1'b0;
    check_eq("bp.pushpop", 64'(count8), 64'd7);
    check_eq("bp.head_addr", addr8, 64'h400A);

    // Reset mid-operation overrides everything else.
    f8_valid = 1'b1; instr_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; f8_valid = 1'b0; instr_ready = 1'b0;
    check_eq("midrst.count", 64'(count8), 64'd0);
    check_eq("midrst.valid", 64'(v8), 64'd0);
    check_eq("midrst.ready", 64'(f8_ready), 64'd1);
    check_eq("midrst.instr", 64'(instr8), 64'd0);
    check_eq("midrst.addr", addr8, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
